// File: rtl/regfile_pkg.sv
// Shared constants, helpers and types for the multi-port register file.
package regfile_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 32;

  // Number of byte strobes for a given register width.
  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  // One writeback-stage write request at the default geometry.
  typedef struct packed {
    logic                        en;
    logic [DEF_ADDR_WIDTH-1:0]   addr;
    logic [DEF_DATA_WIDTH/8-1:0] strb;
    logic [DEF_DATA_WIDTH-1:0]   data;
  } rf_wr_t;

endpackage

// File: rtl/regfile_wr_merge.sv
// Byte-wise merge of every write port that targets one address.
// The same block computes a register's next value and the bypass value for a
// read, so stored data and forwarded data can never disagree.
module regfile_wr_merge
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int NUM_WRITE  = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic [ADDR_WIDTH-1:0]             i_addr,
  input  logic [DATA_WIDTH-1:0]             i_cur,
  input  logic [NUM_WRITE-1:0]              i_wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]   i_wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH/8-1:0] i_wr_strb,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]   i_wr_data,
  output logic [DATA_WIDTH-1:0]             o_next,
  output logic                              o_hit
);

  localparam int SW = strb_width(DATA_WIDTH);

  // Writes to out-of-range addresses or to the hard-wired zero register are dropped.
  logic w_addr_ok;
  assign w_addr_ok = (32'(i_addr) < 32'(NUM_REGS)) &&
                     !((ZERO_REG != 0) && (i_addr == '0));

  // Walk ports low to high so the highest-index port owns each strobed byte.
  always_comb begin
    o_next = i_cur;
    o_hit  = 1'b0;
    if (w_addr_ok) begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (i_wr_en[w] && (i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == i_addr)) begin
          o_hit = 1'b1;
          for (int b = 0; b < SW; b++) begin
            if (i_wr_strb[w*SW + b]) begin
              o_next[b*8 +: 8] = i_wr_data[w*DATA_WIDTH + b*8 +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with byte strobes, optional
// write-to-read bypass and a per-register busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int NUM_READ   = 3,
  parameter int NUM_WRITE  = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_READ-1:0]               rd_en,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]    rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
  output logic [NUM_READ-1:0]               rd_busy,
  input  logic [NUM_WRITE-1:0]              wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]   wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH/8-1:0] wr_strb,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]   wr_data,
  input  logic                              rsv_en,
  input  logic [ADDR_WIDTH-1:0]             rsv_addr,
  output logic [NUM_REGS-1:0]               busy_vec
);

  logic [DATA_WIDTH-1:0]                r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]                  r_busy;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  w_reg_next;
  logic [NUM_REGS-1:0]                  w_busy_next;
  logic [NUM_REGS-1:0]                  w_wr_hit;

  logic [NUM_READ-1:0][DATA_WIDTH-1:0]  w_rd_val;
  logic [NUM_READ-1:0]                  w_rd_bsy;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0]  r_rd_data;
  logic [NUM_READ-1:0]                  r_rd_busy;

  // Per-register next state: merged write data, and busy where a reserve
  // beats a same-cycle write because it names a newer producer.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
      assign w_reg_next[gi]  = '0;
      assign w_wr_hit[gi]    = 1'b0;
      assign w_busy_next[gi] = 1'b0;
      assign busy_vec[gi]    = 1'b0;
    end else begin : g_live
      regfile_wr_merge #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .NUM_WRITE  (NUM_WRITE),
        .ZERO_REG   (ZERO_REG)
      ) u_merge (
        .i_addr    (ADDR_WIDTH'(gi)),
        .i_cur     (r_regs[gi]),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_strb (wr_strb),
        .i_wr_data (wr_data),
        .o_next    (w_reg_next[gi]),
        .o_hit     (w_wr_hit[gi])
      );
      assign w_busy_next[gi] = (rsv_en && (rsv_addr == ADDR_WIDTH'(gi))) ? 1'b1 :
                               (w_wr_hit[gi] ? 1'b0 : r_busy[gi]);
      assign busy_vec[gi]    = r_busy[gi];
    end
  end

  // Read-side selection: invalid addresses read as zero/not-busy; with
  // bypass the post-edge values are taken straight from the merge outputs.
  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic                  w_rok;
    assign w_ra  = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_rok = (32'(w_ra) < 32'(NUM_REGS)) &&
                   !((ZERO_REG != 0) && (w_ra == '0));
    if (BYPASS != 0) begin : g_byp
      assign w_rd_val[gi] = w_rok ? w_reg_next[w_ra]  : '0;
      assign w_rd_bsy[gi] = w_rok ? w_busy_next[w_ra] : 1'b0;
    end else begin : g_nobyp
      assign w_rd_val[gi] = w_rok ? r_regs[w_ra] : '0;
      assign w_rd_bsy[gi] = w_rok ? r_busy[w_ra] : 1'b0;
    end
  end

  // Register array and scoreboard state; reset discards that cycle's writes and reserves.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= w_reg_next[r];
      end
      r_busy <= w_busy_next;
    end
  end

  // Registered read ports; a disabled port holds its last result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
      r_rd_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_READ; i++) begin
        if (rd_en[i]) begin
          r_rd_data[i] <= w_rd_val[i];
          r_rd_busy[i] <= w_rd_bsy[i];
        end
      end
    end
  end

  assign rd_data = r_rd_data;
  assign rd_busy = r_rd_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two instances (bypass on/off) share stimulus; a
// behavioural model pushes expected read results and scoreboards each cycle.
module tb_regfile_mp;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 3;
  localparam int NWR = 2;
  localparam int SW  = DW / 8;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*DW-1:0]   rd_data0, rd_data1;
  logic [NRD-1:0]      rd_busy0, rd_busy1;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*SW-1:0]   wr_strb;
  logic [NWR*DW-1:0]   wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic [NR-1:0]       busy_vec0, busy_vec1;

  regfile_mp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ(NRD),
    .NUM_WRITE(NWR), .ZERO_REG(1), .BYPASS(1)
  ) u_dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_busy(rd_busy0), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_strb(wr_strb), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_vec(busy_vec0)
  );

  regfile_mp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ(NRD),
    .NUM_WRITE(NWR), .ZERO_REG(1), .BYPASS(0)
  ) u_dut_nb (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_busy(rd_busy1), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_strb(wr_strb), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_vec(busy_vec1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;   // 0 = rd_data, 1 = rd_busy, 2 = busy_vec
    int          dut;    // 0 = bypass instance, 1 = no-bypass instance
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_busy;
  logic [DW-1:0] m_last  [2][NRD];
  logic          m_lastb [2][NRD];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NR) && (a != '0);
  endfunction

  task automatic idle();
    reset    = 1'b0;
    rd_en    = '0;
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_strb  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [SW-1:0] s, input logic [DW-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_strb[p*SW +: SW] = s;
    wr_data[p*DW +: DW] = d;
  endtask

  // Model the coming edge, queue expectations, clock, then drain and compare.
  task automatic step(input string name);
    logic [DW-1:0] nregs [NR];
    logic [NR-1:0] nbusy;
    logic [AW-1:0] a;
    logic [31:0]   act;
    exp_t          e;
    if (reset) begin
      for (int r = 0; r < NR; r++) nregs[r] = '0;
      nbusy = '0;
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < NRD; i++) begin
          m_last[d][i]  = '0;
          m_lastb[d][i] = 1'b0;
        end
    end else begin
      for (int r = 0; r < NR; r++) nregs[r] = m_regs[r];
      nbusy = m_busy;
      for (int w = 0; w < NWR; w++) begin
        a = wr_addr[w*AW +: AW];
        if (wr_en[w] && addr_ok(a)) begin
          for (int b = 0; b < SW; b++)
            if (wr_strb[w*SW + b]) nregs[a][b*8 +: 8] = wr_data[w*DW + b*8 +: 8];
          nbusy[a] = 1'b0;
        end
      end
      if (rsv_en && addr_ok(rsv_addr)) nbusy[rsv_addr] = 1'b1;
      for (int i = 0; i < NRD; i++) begin
        a = rd_addr[i*AW +: AW];
        if (rd_en[i]) begin
          if (!addr_ok(a)) begin
            m_last[0][i] = '0;  m_lastb[0][i] = 1'b0;
            m_last[1][i] = '0;  m_lastb[1][i] = 1'b0;
          end else begin
            m_last[0][i] = nregs[a];  m_lastb[0][i] = nbusy[a];
            m_last[1][i] = m_regs[a]; m_lastb[1][i] = m_busy[a];
          end
        end
      end
    end
    for (int r = 0; r < NR; r++) m_regs[r] = nregs[r];
    m_busy = nbusy;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NRD; i++) begin
        sb_q.push_back('{$sformatf("%s.data.d%0d.p%0d", name, d, i), 0, d, i, m_last[d][i]});
        sb_q.push_back('{$sformatf("%s.busy.d%0d.p%0d", name, d, i), 1, d, i, {31'b0, m_lastb[d][i]}});
      end
      sb_q.push_back('{$sformatf("%s.busy_vec.d%0d", name, d), 2, d, 0, m_busy});
    end
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        0:       act = (e.dut == 0) ? rd_data0[e.port*DW +: DW] : rd_data1[e.port*DW +: DW];
        1:       act = {31'b0, (e.dut == 0) ? rd_busy0[e.port] : rd_busy1[e.port]};
        default: act = (e.dut == 0) ? busy_vec0 : busy_vec1;
      endcase
      check(e.tag, act, e.exp);
    end
    $display("step %s: %0d compared so far, %0d mismatched", name, n_cmp, n_err);
  endtask

  initial begin
    for (int r = 0; r < NR; r++) m_regs[r] = '0;
    m_busy = '0;
    idle();

    // Reset state, with reads requested (they must be ignored).
    reset = 1'b1; set_rd(0, 5); set_wr(0, 5, 4'hF, 32'h1234_5678); step("reset");
    idle(); step("reset_hold");

    // Read r5 on every port after reset.
    idle(); set_rd(0, 5); set_rd(1, 5); set_rd(2, 5); step("rd_r5_zero");

    // Write r5 with a same-cycle read: bypass sees new data, the other instance old.
    idle(); set_wr(0, 5, 4'hF, 32'hDEAD_BEEF); set_rd(0, 5); step("wr_rd_r5_bypass");
    idle(); set_rd(0, 5); set_rd(1, 5); set_rd(2, 5); step("rd_r5_after");

    // Byte-wise merge with port1 winning its strobed bytes.
    idle(); set_wr(0, 7, 4'hF, 32'h1122_3344); step("wr_r7_init");
    idle(); set_wr(0, 7, 4'hF, 32'hAAAA_AAAA); set_wr(1, 7, 4'h3, 32'hBBBB_BBBB); set_rd(1, 7);
    step("wr_r7_merge");
    idle(); set_rd(0, 7); set_rd(2, 7); step("rd_r7_merged");

    // Zero register ignores writes and reserves.
    idle(); set_wr(0, 0, 4'hF, 32'hFFFF_FFFF); rsv_en = 1'b1; rsv_addr = 5'd0; set_rd(0, 0);
    step("wr_rsv_r0");
    idle(); set_rd(0, 0); set_rd(1, 0); step("rd_r0");

    // Scoreboard: reserve, reserve+write (reserve wins), write alone.
    idle(); rsv_en = 1'b1; rsv_addr = 5'd3; set_rd(1, 3); step("rsv_r3");
    idle(); rsv_en = 1'b1; rsv_addr = 5'd3; set_wr(1, 3, 4'hF, 32'h0000_0033); set_rd(1, 3);
    step("rsv_wr_r3");
    idle(); set_wr(0, 3, 4'hF, 32'h0000_0333); set_rd(2, 3); step("wr_r3_clear");
    idle(); set_rd(0, 3); set_rd(1, 3); set_rd(2, 3); step("rd_r3");

    // Zero-strobe write leaves data but clears busy; double reserve stays busy.
    idle(); set_wr(0, 6, 4'hF, 32'h6666_6666); rsv_en = 1'b1; rsv_addr = 5'd6; step("wr_rsv_r6");
    idle(); rsv_en = 1'b1; rsv_addr = 5'd6; set_rd(0, 6); step("rsv_r6_again");
    idle(); set_wr(1, 6, 4'h0, 32'hFFFF_FFFF); set_rd(0, 6); step("wr_r6_nostrb");
    idle(); set_wr(0, 9, 4'h5, 32'hCAFE_F00D); set_wr(1, 10, 4'hA, 32'h0BAD_CAFE);
    set_rd(0, 9); set_rd(1, 10); step("wr_partial");

    // Port 2 holds its value while r4 changes underneath it.
    idle(); set_rd(2, 4); step("rd_r4_p2");
    idle(); set_wr(0, 4, 4'hF, 32'h1234_5678); set_rd(0, 4); step("wr_r4_p2_off");
    idle(); set_rd(1, 4); step("rd_r4_p2_hold");

    // Reset during a write/reserve discards both.
    idle(); reset = 1'b1; set_wr(0, 4, 4'hF, 32'h8765_4321); rsv_en = 1'b1; rsv_addr = 5'd8;
    set_rd(0, 4); step("reset_mid");
    idle(); set_rd(0, 4); set_rd(1, 7); set_rd(2, 8); step("rd_after_reset");

    // Random traffic on a small address window to force collisions.
    for (int n = 0; n < 40; n++) begin
      idle();
      reset = ($urandom_range(0, 24) == 0);
      rd_en = NRD'($urandom);
      wr_en = NWR'($urandom);
      for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
      for (int w = 0; w < NWR; w++) begin
        wr_addr[w*AW +: AW] = AW'($urandom_range(0, 7));
        wr_strb[w*SW +: SW] = SW'($urandom);
        wr_data[w*DW +: DW] = $urandom;
      end
      rsv_en   = ($urandom_range(0, 1) == 1);
      rsv_addr = AW'($urandom_range(0, 7));
      step($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
